io_bridge: RTL and testbench

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge.sv | 185 ++++++++++++++++++
 tb/tb_io_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - memory-mapped IO bridge: RAM/VRAM windows, keyboard FIFO, tick counter
module io_bridge #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE     = 32'h0000_0000,
    parameter int                RAM_WORDS    = 1024,
    parameter logic [ADDR_W-1:0] VRAM_BASE    = 32'h0000_1000,
    parameter int                VRAM_WORDS   = 10,
    parameter logic [ADDR_W-1:0] KB_DATA_ADDR = 32'h0000_2000,
    parameter logic [ADDR_W-1:0] KB_STAT_ADDR = 32'h0000_2004,
    parameter logic [ADDR_W-1:0] TICK_ADDR    = 32'h0000_2008,
    parameter int                FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_input,
    output logic [DATA_W-1:0] data_output,
    output logic              ready,
    output logic              error,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_address,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] RAM_SPAN  = (ADDR_W+1)'(4 * RAM_WORDS);
    localparam logic [ADDR_W:0] VRAM_SPAN = (ADDR_W+1)'(4 * VRAM_WORDS);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_dout;
    logic              r_ready;
    logic              r_error;
    logic [DATA_W-1:0] r_tick;
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_ovf;

    logic [ADDR_W:0]   w_ram_off;
    logic [ADDR_W:0]   w_vram_off;
    logic              w_ram_hit;
    logic              w_vram_hit;
    logic              w_kbd_hit;
    logic              w_stat_hit;
    logic              w_tick_hit;
    logic              w_unmapped;
    logic              w_acc;
    logic              w_fifo_ne;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_stat_wr;
    logic              w_tick_wr;
    logic [DATA_W-1:0] w_rd_data;

    // Offsets carry a borrow bit, so addresses below a base fall outside the span.
    assign w_ram_off  = {1'b0, address} - {1'b0, RAM_BASE};
    assign w_vram_off = {1'b0, address} - {1'b0, VRAM_BASE};
    assign w_ram_hit  = w_ram_off < RAM_SPAN;
    assign w_vram_hit = w_vram_off < VRAM_SPAN;
    assign w_kbd_hit  = address == KB_DATA_ADDR;
    assign w_stat_hit = address == KB_STAT_ADDR;
    assign w_tick_hit = address == TICK_ADDR;
    assign w_unmapped = !(w_ram_hit || w_vram_hit || w_kbd_hit || w_stat_hit || w_tick_hit);

    assign w_acc     = !rst && (r_state == IDLE) && req;
    assign w_fifo_ne = r_count != '0;
    assign w_full    = r_count == (PW+1)'(FIFO_DEPTH);
    assign w_pop     = w_acc && !write_enable && w_kbd_hit && w_fifo_ne;
    assign w_push    = kb_valid && (!w_full || w_pop);
    assign w_stat_wr = w_acc && write_enable && w_stat_hit;
    assign w_tick_wr = w_acc && write_enable && w_tick_hit;

    assign ram_en       = w_acc && w_ram_hit;
    assign ram_we       = ram_en && write_enable;
    assign ram_address  = {2'b00, w_ram_off[ADDR_W-1:2]};
    assign ram_wdata    = data_input;
    assign vram_we      = w_acc && w_vram_hit && write_enable;
    assign vram_address = {2'b00, w_vram_off[ADDR_W-1:2]};
    assign vram_wdata   = data_input;

    assign data_output = r_dout;
    assign ready       = r_ready;
    assign error       = r_error;

    always_comb begin
        w_rd_data = '0;
        if (w_vram_hit) begin
            w_rd_data = vram_rdata;
        end else if (w_kbd_hit) begin
            if (w_fifo_ne) w_rd_data[7:0] = r_fifo[r_rd_ptr];
        end else if (w_stat_hit) begin
            w_rd_data[0]    = w_fifo_ne;
            w_rd_data[1]    = w_full;
            w_rd_data[2]    = r_ovf;
            w_rd_data[15:8] = 8'(r_count);
        end else if (w_tick_hit) begin
            w_rd_data = r_tick;
        end
    end

    // ready/error/data_output are registered out of RESP, one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        if (w_ram_hit && !write_enable) begin
                            r_state <= RAM_WAIT;
                        end else begin
                            r_rdata <= write_enable ? '0 : w_rd_data;
                            r_err   <= w_unmapped;
                            r_state <= RESP;
                        end
                    end
                end
                RAM_WAIT: begin
                    r_rdata <= ram_rdata;
                    r_err   <= 1'b0;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_error <= r_err;
                    r_dout  <= r_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_fifo[r_wr_ptr] <= kb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
            // A drop in the same cycle as a clear leaves overflow set.
            if (w_stat_wr && data_input[2]) r_ovf <= 1'b0;
            if (kb_valid && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            r_tick <= '0;
        else if (w_tick_wr) r_tick <= data_input;
        else                r_tick <= r_tick + DATA_W'(1);
    end

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - self-checking bench for io_bridge
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_input = '0;
    logic [31:0] data_output;
    logic        ready;
    logic        error;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        vram_we;
    logic [31:0] vram_address;
    logic [31:0] vram_wdata;
    logic [31:0] vram_rdata;

    io_bridge dut (
        .clk(clk), .rst(rst), .req(req), .write_enable(write_enable),
        .address(address), .data_input(data_input), .data_output(data_output),
        .ready(ready), .error(error), .kb_valid(kb_valid), .kb_data(kb_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .vram_we(vram_we),
        .vram_address(vram_address), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    // External memories
    logic [31:0] ram_mem [0:1023];
    logic [31:0] vram_mem [0:9];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_address[9:0]] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_address[9:0]];
        if (vram_we && vram_address < 32'd10) vram_mem[vram_address[3:0]] <= vram_wdata;
    end
    assign vram_rdata = (vram_address < 32'd10) ? vram_mem[vram_address[3:0]] : 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!rst && ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(ready), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", data_output, e.data);
                check("rsp_error", 32'(error), 32'(e.err));
                check("rsp_latency", 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_sb();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check("ready_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee, input int lat,
                          input logic [2:0] strb, input logic [31:0] idx,
                          input logic kbv, input logic [7:0] kbd);
        exp_t e;
        @(posedge clk); #1;
        req = 1'b1; write_enable = we; address = a; data_input = d;
        kb_valid = kbv; kb_data = kbd;
        e.data = ed; e.err = ee; e.cyc = cyc; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        check("strobes", {29'h0, ram_en, ram_we, vram_we}, {29'h0, strb});
        if (strb[2]) check("ram_address", ram_address, idx);
        if (strb[1]) check("ram_wdata", ram_wdata, d);
        if (strb[0]) check("vram_address", vram_address, idx);
        if (strb[0]) check("vram_wdata", vram_wdata, d);
        @(posedge clk); #1;
        req = 1'b0; write_enable = 1'b0; kb_valid = 1'b0;
        wait_sb();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ee);
        access(1'b0, a, 32'h0, ed, ee, 2, 3'b000, 32'h0, 1'b0, 8'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic ee);
        access(1'b1, a, d, 32'h0, ee, 2, 3'b000, 32'h0, 1'b0, 8'h0);
    endtask

    task automatic kb_push(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            kb_valid = 1'b1; kb_data = first + 8'(i);
        end
        @(posedge clk); #1;
        kb_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat;
        logic [2:0]  strb;
        logic [31:0] idx;
    } vec_t;
    vec_t vecs [16];

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
        for (int i = 0; i < 10; i++) vram_mem[i] = 32'h100 + 32'(i);
        ram_mem[4]    = 32'h0000_CAFE;
        ram_mem[1023] = 32'h0000_BEEF;

        vecs[0]  = '{1'b1, 32'h1008, 32'h55,   32'h0,     1'b0, 2, 3'b001, 32'd2};
        vecs[1]  = '{1'b0, 32'h1008, 32'h0,    32'h55,    1'b0, 2, 3'b000, 32'd0};
        vecs[2]  = '{1'b1, 32'h0020, 32'h1234, 32'h0,     1'b0, 2, 3'b110, 32'd8};
        vecs[3]  = '{1'b0, 32'h0020, 32'h0,    32'h1234,  1'b0, 3, 3'b100, 32'd8};
        vecs[4]  = '{1'b0, 32'h0010, 32'h0,    32'hCAFE,  1'b0, 3, 3'b100, 32'd4};
        vecs[5]  = '{1'b0, 32'h0013, 32'h0,    32'hCAFE,  1'b0, 3, 3'b100, 32'd4};
        vecs[6]  = '{1'b0, 32'h0FFC, 32'h0,    32'hBEEF,  1'b0, 3, 3'b100, 32'd1023};
        vecs[7]  = '{1'b0, 32'h1000, 32'h0,    32'h100,   1'b0, 2, 3'b000, 32'd0};
        vecs[8]  = '{1'b0, 32'h1024, 32'h0,    32'h109,   1'b0, 2, 3'b000, 32'd0};
        vecs[9]  = '{1'b0, 32'h1028, 32'h0,    32'h0,     1'b1, 2, 3'b000, 32'd0};
        vecs[10] = '{1'b1, 32'h3000, 32'h99,   32'h0,     1'b1, 2, 3'b000, 32'd0};
        vecs[11] = '{1'b0, 32'h2001, 32'h0,    32'h0,     1'b1, 2, 3'b000, 32'd0};
        vecs[12] = '{1'b0, 32'h2004, 32'h0,    32'h0,     1'b0, 2, 3'b000, 32'd0};
        vecs[13] = '{1'b0, 32'h2000, 32'h0,    32'h0,     1'b0, 2, 3'b000, 32'd0};
        vecs[14] = '{1'b1, 32'h2000, 32'hAB,   32'h0,     1'b0, 2, 3'b000, 32'd0};
        vecs[15] = '{1'b1, 32'h1024, 32'h77,   32'h0,     1'b0, 2, 3'b001, 32'd9};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_data", data_output, 32'h0);
        check("rst_strobes", {29'h0, ram_en, ram_we, vram_we}, 32'h0);

        foreach (vecs[i])
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
                   vecs[i].exp_err, vecs[i].lat, vecs[i].strb, vecs[i].idx, 1'b0, 8'h0);
        check("vram9_model", vram_mem[9], 32'h77);

        // RAM read, with a second request held through RAM_WAIT and RESP
        begin
            exp_t e;
            @(posedge clk); #1;
            req = 1'b1; write_enable = 1'b0; address = 32'h10;
            e.data = 32'hCAFE; e.err = 1'b0; e.cyc = cyc; e.lat = 3;
            sb.push_back(e);
            @(negedge clk);
            check("w22_ram_en", 32'(ram_en), 32'h1);
            check("w22_ram_addr", ram_address, 32'd4);
            @(posedge clk); #1;
            write_enable = 1'b1; address = 32'h1000; data_input = 32'hDEAD;
            @(negedge clk);
            check("w22_wait_strobes", {29'h0, ram_en, ram_we, vram_we}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            check("w22_resp_strobes", {29'h0, ram_en, ram_we, vram_we}, 32'h0);
            @(posedge clk); #1;
            req = 1'b0; write_enable = 1'b0;
            wait_sb();
            repeat (4) @(negedge clk);
            check("w22_vram0_kept", vram_mem[0], 32'h100);
        end

        // Overflow, drain and overflow clear
        kb_push(8'h01, 9);
        rd(32'h2004, 32'h0807, 1'b0);
        for (int i = 1; i <= 8; i++) rd(32'h2000, 32'(i), 1'b0);
        rd(32'h2004, 32'h0004, 1'b0);
        wr(32'h2004, 32'h4, 1'b0);
        rd(32'h2004, 32'h0000, 1'b0);

        // Push coincident with pop while full, then while empty
        kb_push(8'h11, 8);
        access(1'b0, 32'h2000, 32'h0, 32'h11, 1'b0, 2, 3'b000, 32'h0, 1'b1, 8'h19);
        rd(32'h2004, 32'h0803, 1'b0);
        for (int i = 0; i < 8; i++) rd(32'h2000, 32'h12 + 32'(i), 1'b0);
        rd(32'h2004, 32'h0000, 1'b0);
        access(1'b0, 32'h2000, 32'h0, 32'h0, 1'b0, 2, 3'b000, 32'h0, 1'b1, 8'h77);
        rd(32'h2004, 32'h0101, 1'b0);
        rd(32'h2000, 32'h77, 1'b0);

        // Tick load and wrap
        wr(32'h2008, 32'hFFFF_FFFE, 1'b0);
        rd(32'h2008, 32'h0, 1'b0);
        rd(32'h2008, 32'h3, 1'b0);
        rd(32'h3000, 32'h0, 1'b1);

        // Reset during RAM_WAIT
        kb_push(8'h31, 2);
        rd(32'h2004, 32'h0201, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; write_enable = 1'b0; address = 32'h40;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1; kb_valid = 1'b1; kb_data = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b0; kb_valid = 1'b0;
        @(negedge clk);
        check("r26_ready", 32'(ready), 32'h0);
        check("r26_error", 32'(error), 32'h0);
        check("r26_data", data_output, 32'h0);
        check("r26_strobes", {29'h0, ram_en, ram_we, vram_we}, 32'h0);
        repeat (4) @(negedge clk);
        rd(32'h2004, 32'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
